// File: rtl/note_input_ctrl.sv
// Pushbutton front end for the note display: synchronizes and debounces four keys,
// then sequences note/octave updates and a one-cycle load strobe to the glyph drawer.
module note_input_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          HOLDOFF_CYCLES  = 448,
  parameter logic [7:0]  X_POS           = 8'd60,
  parameter logic [6:0]  Y_POS           = 7'd50
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_note_up_n,
  input  logic       key_note_down_n,
  input  logic       key_oct_up_n,
  input  logic       key_oct_down_n,
  input  logic [2:0] colour_sel,
  output logic [3:0] note,
  output logic [1:0] octave,
  output logic       ld_note,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       busy
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_ZERO  = DW'(0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_ZERO = HW'(0);

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Key bit order: 0 note_up, 1 note_down, 2 oct_up, 3 oct_down (also the priority order).
  logic [3:0]    w_keys;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb;
  logic [3:0]    r_deb_prev;
  logic [DW-1:0] r_cnt [4];
  logic [3:0]    w_press;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [HW-1:0] r_hold_cnt;
  logic [3:0]    r_note;
  logic [3:0]    w_note_nxt;
  logic [1:0]    r_oct;
  logic [1:0]    w_oct_nxt;
  logic [2:0]    r_col;
  logic [2:0]    w_col_nxt;
  logic          r_ld;
  logic          r_busy;

  assign w_keys  = {key_oct_down_n, key_oct_up_n, key_note_down_n, key_note_up_n};
  assign w_press = r_deb_prev & ~r_deb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 4'b1111;
      r_sync2 <= 4'b1111;
    end else begin
      r_sync1 <= w_keys;
      r_sync2 <= r_sync1;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES samples that all differ from the current one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_deb      <= 4'b1111;
      r_deb_prev <= 4'b1111;
      for (int i = 0; i < 4; i++) r_cnt[i] <= DEB_ZERO;
    end else begin
      r_deb_prev <= r_deb;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= DEB_ZERO;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= DEB_ZERO;
        end else begin
          r_cnt[i] <= r_cnt[i] + DEB_ONE;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT: w_next = ST_LOAD;
      ST_LOAD: w_next = ST_HOLD;
      ST_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) w_next = ST_IDLE;
        else                         w_next = ST_HOLD;
      end
      ST_IDLE: begin
        if (|w_press) w_next = ST_LOAD;
        else          w_next = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // Only one event is honoured per load; lower-priority simultaneous events are dropped.
  always_comb begin
    w_note_nxt = r_note;
    w_oct_nxt  = r_oct;
    w_col_nxt  = r_col;
    if (r_state == ST_IDLE && (|w_press)) begin
      w_col_nxt = colour_sel;
      if (w_press[0]) begin
        w_note_nxt = (r_note == 4'd12) ? 4'd1 : r_note + 4'd1;
      end else if (w_press[1]) begin
        w_note_nxt = (r_note == 4'd1) ? 4'd12 : r_note - 4'd1;
      end else if (w_press[2]) begin
        w_oct_nxt = r_oct + 2'd1;
      end else begin
        w_oct_nxt = r_oct - 2'd1;
      end
    end else if (r_state == ST_INIT) begin
      w_col_nxt = colour_sel;
    end else begin
      w_col_nxt = r_col;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_INIT;
      r_hold_cnt <= HOLD_ZERO;
      r_note     <= 4'd1;
      r_oct      <= 2'd0;
      r_col      <= 3'd0;
      r_ld       <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_hold_cnt <= (r_state == ST_HOLD) ? r_hold_cnt + HOLD_ONE : HOLD_ZERO;
      r_note     <= w_note_nxt;
      r_oct      <= w_oct_nxt;
      r_col      <= w_col_nxt;
      r_ld       <= (w_next == ST_LOAD);
      r_busy     <= (w_next != ST_IDLE);
    end
  end

  assign note    = r_note;
  assign octave  = r_oct;
  assign colour  = r_col;
  assign ld_note = r_ld;
  assign busy    = r_busy;
  assign x       = X_POS;
  assign y       = Y_POS;

endmodule

// File: tb/tb_note_input_ctrl.sv
// Directed bench for note_input_ctrl: a cycle-level reference model of the key rules is
// compared with the DUT every cycle, and hand-computed values pin the key scenarios.
module tb_note_input_ctrl;

  localparam int D = 4;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] keys_n = 4'b1111;
  logic [2:0] colour_sel = 3'b010;
  logic [3:0] note;
  logic [1:0] octave;
  logic       ld_note;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int ld_total = 0;
  int base;

  // Reference model state: age counts cycles since the last load strobe.
  int       m_note, m_oct, m_col, m_age;
  bit       m_init;
  bit [3:0] m_s1, m_s2, m_deb, m_prv;
  int       m_run [4];

  note_input_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_CYCLES (H),
    .X_POS          (8'd60),
    .Y_POS          (7'd50)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .key_note_up_n  (keys_n[0]),
    .key_note_down_n(keys_n[1]),
    .key_oct_up_n   (keys_n[2]),
    .key_oct_down_n (keys_n[3]),
    .colour_sel     (colour_sel),
    .note           (note),
    .octave         (octave),
    .ld_note        (ld_note),
    .x              (x),
    .y              (y),
    .colour         (colour),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_note = 1; m_oct = 0; m_col = 0; m_init = 1'b1; m_age = H + 1;
    m_s1 = 4'b1111; m_s2 = 4'b1111; m_deb = 4'b1111; m_prv = 4'b1111;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endtask

  task automatic model_step();
    bit [3:0] ev;
    ev = m_prv & ~m_deb;
    if (m_init) begin
      m_init = 1'b0; m_age = 0; m_col = int'(colour_sel);
    end else if (m_age > H && ev != 4'b0000) begin
      if      (ev[0]) m_note = (m_note % 12) + 1;
      else if (ev[1]) m_note = ((m_note + 10) % 12) + 1;
      else if (ev[2]) m_oct  = (m_oct + 1) % 4;
      else            m_oct  = (m_oct + 3) % 4;
      m_age = 0; m_col = int'(colour_sel);
    end else if (m_age <= H) begin
      m_age++;
    end
    for (int k = 0; k < 4; k++) begin
      m_prv[k] = m_deb[k];
      if (m_s2[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_deb[k] = m_s2[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
      m_s2[k] = m_s1[k];
      m_s1[k] = keys_n[k];
    end
  endtask

  task automatic compare();
    chk("note", int'(note), m_note);
    chk("octave", int'(octave), m_oct);
    chk("colour", int'(colour), m_col);
    chk("ld_note", int'(ld_note), (!m_init && m_age == 0) ? 1 : 0);
    chk("busy", int'(busy), (m_init || m_age <= H) ? 1 : 0);
    chk("x", int'(x), 60);
    chk("y", int'(y), 50);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int k, input int lo, input int hi);
    keys_n[k] = 1'b0;
    cyc(lo);
    keys_n[k] = 1'b1;
    cyc(hi);
  endtask

  initial begin
    model_reset();
    fork
      forever begin
        @(posedge clk or negedge resetn);
        if (!resetn) model_reset();
        else         model_step();
      end
      forever begin
        @(negedge clk);
        compare();
        if (ld_note) ld_total++;
      end
    join_none

    cyc(3);
    chk("rst_note", int'(note), 1);
    chk("rst_busy", int'(busy), 1);
    chk("rst_ld", int'(ld_note), 0);
    chk("rst_colour", int'(colour), 0);

    resetn = 1'b1;
    base = ld_total;
    cyc(1);
    chk("boot_ld_strobe", int'(ld_note), 1);
    cyc(19);
    chk("boot_ld_count", ld_total - base, 1);
    chk("boot_colour", int'(colour), 2);
    chk("boot_busy", int'(busy), 0);

    base = ld_total;
    press(0, 30, 16);
    chk("long_press_ld_count", ld_total - base, 1);
    chk("long_press_note", int'(note), 2);
    press(0, 12, 16);
    chk("second_press_note", int'(note), 3);

    for (int i = 0; i < 9; i++) press(0, 12, 16);
    chk("note_at_12", int'(note), 12);
    press(0, 12, 16);
    chk("wrap_up_note", int'(note), 1);
    press(1, 12, 16);
    chk("wrap_down_note", int'(note), 12);

    for (int i = 0; i < 3; i++) press(2, 12, 16);
    chk("octave_at_3", int'(octave), 3);
    press(2, 12, 16);
    chk("wrap_oct_up", int'(octave), 0);
    press(3, 12, 16);
    chk("wrap_oct_down", int'(octave), 3);
    press(2, 12, 16);

    base = ld_total;
    press(0, 3, 20);
    chk("glitch_ld_count", ld_total - base, 0);
    chk("glitch_note", int'(note), 12);

    base = ld_total;
    keys_n[0] = 1'b0;
    keys_n[2] = 1'b0;
    cyc(4);
    keys_n[3] = 1'b0;
    cyc(8);
    keys_n[0] = 1'b1;
    keys_n[2] = 1'b1;
    cyc(4);
    keys_n[3] = 1'b1;
    cyc(20);
    chk("simul_ld_count", ld_total - base, 1);
    chk("simul_note", int'(note), 1);
    chk("simul_octave", int'(octave), 0);

    for (int i = 0; i < 5; i++) press(0, 12, 16);
    keys_n[0] = 1'b0;
    cyc(10);
    keys_n[0] = 1'b1;
    cyc(2);
    chk("pre_reset_note", int'(note), 7);
    chk("pre_reset_busy", int'(busy), 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_note", int'(note), 1);
    chk("async_rst_octave", int'(octave), 0);
    chk("async_rst_colour", int'(colour), 0);
    chk("async_rst_ld", int'(ld_note), 0);
    chk("async_rst_busy", int'(busy), 1);
    cyc(3);
    resetn = 1'b1;
    base = ld_total;
    cyc(20);
    chk("rerun_ld_count", ld_total - base, 1);
    chk("rerun_note", int'(note), 1);
    chk("rerun_colour", int'(colour), 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
